// File: rtl/letter_tx_queue.sv
// letter_tx_queue
//
// Buffers encoded enigma letters between the encoder output and the IR
// transmitter. Letters arrive as single-cycle push strobes. They are held in
// a circular buffer and released one at a time through a busy handshake with
// the transmitter.
//
// Ports
//   clk_in             system clock
//   rst_in             asynchronous, active-high reset
//   data_valid_in      push strobe; every high cycle is one push
//   data_in            symbol to push
//   flush_in           synchronous clear of stored contents
//   tx_busy_in         transmitter busy flag
//   data_valid_out     one-cycle issue strobe to the transmitter
//   data_out           issued symbol, held until the next issue
//   count_out          number of stored entries
//   empty_out          count_out == 0
//   full_out           count_out == DEPTH
//   overflow_count_out dropped pushes, saturating at 16'hFFFF
//   timeout_out        one-cycle pulse when busy is never acknowledged
module letter_tx_queue #(
  parameter int unsigned WIDTH        = 5,
  parameter int unsigned DEPTH        = 1000,
  parameter int unsigned BUSY_TIMEOUT = 1024
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       data_valid_in,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       flush_in,
  input  logic                       tx_busy_in,
  output logic                       data_valid_out,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       empty_out,
  output logic                       full_out,
  output logic [15:0]                overflow_count_out,
  output logic                       timeout_out
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [PW-1:0] PtrLast   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);
  localparam logic [TW-1:0] TimerLast = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StWaitDone
  } state_e;

  // Storage and bookkeeping
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic [15:0]      r_ovf;

  // Issue handshake
  state_e           r_state;
  logic [TW-1:0]    r_timer;
  logic             r_dvo;
  logic [WIDTH-1:0] r_dout;
  logic             r_timeout;

  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_count_d;
  logic [PW-1:0]    w_wp_inc;
  logic [PW-1:0]    w_rp_inc;

  // An issue is the only way an entry leaves the buffer.
  assign w_pop  = (r_state == StIdle) && !r_empty && !tx_busy_in && !flush_in;

  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign w_push = data_valid_in && !flush_in && (!r_full || w_pop);
  assign w_drop = data_valid_in && !flush_in && r_full && !w_pop;

  // DEPTH need not be a power of two, so wrap explicitly.
  assign w_wp_inc = (r_wp == PtrLast) ? '0 : r_wp + PW'(1);
  assign w_rp_inc = (r_rp == PtrLast) ? '0 : r_rp + PW'(1);

  always_comb begin
    w_count_d = r_count;
    if (flush_in) begin
      w_count_d = '0;
    end else if (w_push && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CW'(1);
    end
  end

  // Buffer contents carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wp] <= data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= '0;
    end else begin
      if (flush_in) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_push) begin
          r_wp <= w_wp_inc;
        end
        if (w_pop) begin
          r_rp <= w_rp_inc;
        end
      end
      if (w_drop && (r_ovf != 16'hFFFF)) begin
        r_ovf <= r_ovf + 16'd1;
      end
      r_count <= w_count_d;
      r_empty <= (w_count_d == '0);
      r_full  <= (w_count_d == CountFull);
    end
  end

  // Issue FSM. A flush never changes the state; it only blocks a new issue.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_dvo     <= 1'b0;
      r_dout    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_dvo     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_dvo   <= 1'b1;
            r_dout  <= r_mem[r_rp];
            r_timer <= '0;
            r_state <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (tx_busy_in) begin
            r_state <= StWaitDone;
          end else if (r_timer == TimerLast) begin
            // The letter is treated as consumed; it is not re-queued.
            r_timeout <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        StWaitDone: begin
          if (!tx_busy_in) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign data_valid_out     = r_dvo;
  assign data_out           = r_dout;
  assign count_out          = r_count;
  assign empty_out          = r_empty;
  assign full_out           = r_full;
  assign overflow_count_out = r_ovf;
  assign timeout_out        = r_timeout;

endmodule

// File: tb/tb_letter_tx_queue.sv
module tb_letter_tx_queue;

  localparam int unsigned W  = 5;
  localparam int unsigned DA = 4;
  localparam int unsigned DB = 5;
  localparam int unsigned BT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // DUT A: DEPTH=4
  logic         a_dv = 1'b0;
  logic [W-1:0] a_din = '0;
  logic         a_flush = 1'b0;
  logic         a_busy = 1'b0;
  logic         a_dvo;
  logic [W-1:0] a_dout;
  logic [2:0]   a_count;
  logic         a_empty;
  logic         a_full;
  logic [15:0]  a_ovf;
  logic         a_tmo;

  // DUT B: DEPTH=5 (non power of two)
  logic         b_dv = 1'b0;
  logic [W-1:0] b_din = '0;
  logic         b_flush = 1'b0;
  logic         b_busy = 1'b0;
  logic         b_dvo;
  logic [W-1:0] b_dout;
  logic [2:0]   b_count;
  logic         b_empty;
  logic         b_full;
  logic [15:0]  b_ovf;
  logic         b_tmo;

  int n_checks = 0;
  int n_pass   = 0;

  letter_tx_queue #(.WIDTH(W), .DEPTH(DA), .BUSY_TIMEOUT(BT)) dut_a (
    .clk_in             (clk),
    .rst_in             (rst),
    .data_valid_in      (a_dv),
    .data_in            (a_din),
    .flush_in           (a_flush),
    .tx_busy_in         (a_busy),
    .data_valid_out     (a_dvo),
    .data_out           (a_dout),
    .count_out          (a_count),
    .empty_out          (a_empty),
    .full_out           (a_full),
    .overflow_count_out (a_ovf),
    .timeout_out        (a_tmo)
  );

  letter_tx_queue #(.WIDTH(W), .DEPTH(DB), .BUSY_TIMEOUT(BT)) dut_b (
    .clk_in             (clk),
    .rst_in             (rst),
    .data_valid_in      (b_dv),
    .data_in            (b_din),
    .flush_in           (b_flush),
    .tx_busy_in         (b_busy),
    .data_valid_out     (b_dvo),
    .data_out           (b_dout),
    .count_out          (b_count),
    .empty_out          (b_empty),
    .full_out           (b_full),
    .overflow_count_out (b_ovf),
    .timeout_out        (b_tmo)
  );

  always #5 clk = ~clk;

  // Reference model for DUT A: a queue of stored letters plus the
  // transmitter-handshake view (waiting for acknowledge / transmitter busy).
  int m_q[$];
  bit m_dvo;
  bit m_tmo;
  int m_dout;
  int m_ovf;
  bit m_wait_ack;
  bit m_in_tx;
  int m_wait;

  always @(posedge clk or posedge rst) begin
    bit issue;
    bit was_full;
    if (rst) begin
      m_q.delete();
      m_dvo = 0; m_tmo = 0; m_dout = 0; m_ovf = 0;
      m_wait_ack = 0; m_in_tx = 0; m_wait = 0;
    end else begin
      issue    = !m_wait_ack && !m_in_tx && (m_q.size() > 0) && !a_busy && !a_flush;
      was_full = (m_q.size() == DA);
      m_dvo = issue;
      m_tmo = 0;
      if (m_wait_ack) begin
        if (a_busy) begin
          m_wait_ack = 0;
          m_in_tx    = 1;
        end else begin
          m_wait = m_wait + 1;
          if (m_wait == BT) begin
            m_tmo      = 1;
            m_wait_ack = 0;
          end
        end
      end else if (m_in_tx && !a_busy) begin
        m_in_tx = 0;
      end
      if (a_flush) begin
        m_q.delete();
      end else begin
        if (issue) begin
          m_dout     = m_q.pop_front();
          m_wait_ack = 1;
          m_wait     = 0;
        end
        if (a_dv) begin
          if (!was_full || issue) m_q.push_back(int'(a_din));
          else if (m_ovf < 65535) m_ovf = m_ovf + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_dv = 0; a_flush = 0; a_busy = 0;
    b_dv = 0; b_busy = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    bit seen;
    do_reset();
    n_checks++; if (a_dvo !== 1'b0) $display("FAIL rst_dvo: got %0b, expected 0", a_dvo); else n_pass++;
    n_checks++; if (a_count !== 3'd0) $display("FAIL rst_count: got %0d, expected 0", a_count); else n_pass++;
    n_checks++; if (a_empty !== 1'b1) $display("FAIL rst_empty: got %0b, expected 1", a_empty); else n_pass++;
    n_checks++; if (a_full !== 1'b0) $display("FAIL rst_full: got %0b, expected 0", a_full); else n_pass++;
    n_checks++; if (a_ovf !== 16'd0) $display("FAIL rst_ovf: got %0d, expected 0", a_ovf); else n_pass++;
    n_checks++; if (a_tmo !== 1'b0) $display("FAIL rst_tmo: got %0b, expected 0", a_tmo); else n_pass++;
    // Push 3,4,5,6; the first issues on the second edge, leaving 3 stored.
    a_dv = 1;
    for (int i = 0; i < 4; i++) begin
      a_din = W'(i + 3);
      step();
    end
    a_dv = 0;
    n_checks++; if (a_count !== 3'd3) $display("FAIL pre_rst_count: got %0d, expected 3", a_count); else n_pass++;
    n_checks++; if (a_dout !== 5'd3) $display("FAIL pre_rst_dout: got %0d, expected 3", a_dout); else n_pass++;
    #2 rst = 1;
    #1;
    n_checks++; if (a_count !== 3'd0) $display("FAIL mid_rst_count: got %0d, expected 0", a_count); else n_pass++;
    n_checks++; if (a_empty !== 1'b1) $display("FAIL mid_rst_empty: got %0b, expected 1", a_empty); else n_pass++;
    n_checks++; if (a_dout !== 5'd0) $display("FAIL mid_rst_dout: got %0d, expected 0", a_dout); else n_pass++;
    @(posedge clk);
    #1 rst = 0;
    seen = 0;
    repeat (12) begin
      step();
      if (a_dvo) seen = 1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL post_rst_issue: got %0b, expected 0", seen); else n_pass++;
  endtask

  task automatic test_latency();
    bit seen;
    do_reset();
    a_dv = 1; a_din = 5'd7;
    step();
    a_dv = 0;
    n_checks++; if (a_dvo !== 1'b0) $display("FAIL lat_dvo_e: got %0b, expected 0", a_dvo); else n_pass++;
    n_checks++; if (a_count !== 3'd1) $display("FAIL lat_count_e: got %0d, expected 1", a_count); else n_pass++;
    step();
    n_checks++; if (a_dvo !== 1'b1) $display("FAIL lat_dvo: got %0b, expected 1", a_dvo); else n_pass++;
    n_checks++; if (a_dout !== 5'd7) $display("FAIL lat_dout: got %0d, expected 7", a_dout); else n_pass++;
    n_checks++; if (a_count !== 3'd0) $display("FAIL lat_count: got %0d, expected 0", a_count); else n_pass++;
    // Transmitter raises busy one cycle after the issue, holds it 10 cycles.
    a_busy = 1; a_dv = 1; a_din = 5'd9;
    step();
    a_dv = 0;
    n_checks++; if (a_dvo !== 1'b0) $display("FAIL lat_pulse: got %0b, expected 0", a_dvo); else n_pass++;
    n_checks++; if (a_count !== 3'd1) $display("FAIL lat_count2: got %0d, expected 1", a_count); else n_pass++;
    seen = 0;
    repeat (9) begin
      step();
      if (a_dvo) seen = 1;
    end
    a_busy = 0;
    step();
    if (a_dvo) seen = 1;
    n_checks++; if (seen !== 1'b0) $display("FAIL lat_busy_block: got %0b, expected 0", seen); else n_pass++;
    step();
    n_checks++; if (a_dvo !== 1'b1) $display("FAIL lat_reissue: got %0b, expected 1", a_dvo); else n_pass++;
    n_checks++; if (a_dout !== 5'd9) $display("FAIL lat_dout2: got %0d, expected 9", a_dout); else n_pass++;
  endtask

  task automatic test_overflow();
    int w[6];
    int issued;
    int busy_cnt;
    do_reset();
    a_busy = 1;
    for (int i = 0; i < 6; i++) begin
      w[i] = int'($urandom_range(0, 31));
      a_dv = 1; a_din = W'(w[i]);
      step();
      if (i == 3) begin
        n_checks++; if (a_full !== 1'b1) $display("FAIL ovf_full4: got %0b, expected 1", a_full); else n_pass++;
      end
    end
    a_dv = 0;
    n_checks++; if (a_ovf !== 16'd2) $display("FAIL ovf_count: got %0d, expected 2", a_ovf); else n_pass++;
    n_checks++; if (a_count !== 3'd4) $display("FAIL ovf_depth: got %0d, expected 4", a_count); else n_pass++;
    issued = 0; busy_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      a_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      step();
      if (a_dvo) begin
        if (issued < 4) begin
          n_checks++;
          if (int'(a_dout) !== w[issued])
            $display("FAIL ovf_order[%0d]: got %0d, expected %0d", issued, a_dout, w[issued]);
          else n_pass++;
        end
        issued++;
        busy_cnt = 2;
      end
    end
    n_checks++; if (issued !== 4) $display("FAIL ovf_issued: got %0d, expected 4", issued); else n_pass++;
  endtask

  task automatic test_simul_push_pop();
    int w[5];
    int issued;
    int busy_cnt;
    do_reset();
    a_busy = 1;
    for (int i = 0; i < 5; i++) w[i] = int'($urandom_range(0, 31));
    for (int i = 0; i < 4; i++) begin
      a_dv = 1; a_din = W'(w[i]);
      step();
    end
    n_checks++; if (a_full !== 1'b1) $display("FAIL sim_full: got %0b, expected 1", a_full); else n_pass++;
    a_busy = 0; a_dv = 1; a_din = W'(w[4]);
    step();
    a_dv = 0;
    n_checks++; if (a_dvo !== 1'b1) $display("FAIL sim_dvo: got %0b, expected 1", a_dvo); else n_pass++;
    n_checks++; if (int'(a_dout) !== w[0]) $display("FAIL sim_dout: got %0d, expected %0d", a_dout, w[0]); else n_pass++;
    n_checks++; if (a_count !== 3'd4) $display("FAIL sim_count: got %0d, expected 4", a_count); else n_pass++;
    n_checks++; if (a_ovf !== 16'd0) $display("FAIL sim_ovf: got %0d, expected 0", a_ovf); else n_pass++;
    issued = 1; busy_cnt = 2;
    for (int c = 0; c < 80; c++) begin
      a_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      step();
      if (a_dvo) begin
        if (issued < 5) begin
          n_checks++;
          if (int'(a_dout) !== w[issued])
            $display("FAIL sim_order[%0d]: got %0d, expected %0d", issued, a_dout, w[issued]);
          else n_pass++;
        end
        issued++;
        busy_cnt = 2;
      end
    end
    n_checks++; if (issued !== 5) $display("FAIL sim_issued: got %0d, expected 5", issued); else n_pass++;
  endtask

  task automatic test_timeout();
    int w0, w1;
    int tmo_at, dvo_at, pulses, dout_at;
    do_reset();
    w0 = int'($urandom_range(0, 31));
    w1 = int'($urandom_range(0, 31));
    a_dv = 1; a_din = W'(w0);
    step();
    a_din = W'(w1);
    step();
    a_dv = 0;
    n_checks++; if (a_dvo !== 1'b1) $display("FAIL to_issue: got %0b, expected 1", a_dvo); else n_pass++;
    n_checks++; if (int'(a_dout) !== w0) $display("FAIL to_dout0: got %0d, expected %0d", a_dout, w0); else n_pass++;
    tmo_at = -1; dvo_at = -1; pulses = 0; dout_at = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (a_tmo) begin
        pulses++;
        if (tmo_at < 0) tmo_at = k;
      end
      if (a_dvo && dvo_at < 0) begin
        dvo_at  = k;
        dout_at = int'(a_dout);
      end
    end
    n_checks++; if (tmo_at !== BT) $display("FAIL to_delay: got %0d, expected %0d", tmo_at, BT); else n_pass++;
    n_checks++; if (dvo_at !== BT + 1) $display("FAIL to_next_issue: got %0d, expected %0d", dvo_at, BT + 1); else n_pass++;
    n_checks++; if (dout_at !== w1) $display("FAIL to_dout1: got %0d, expected %0d", dout_at, w1); else n_pass++;
    n_checks++; if (pulses !== 2) $display("FAIL to_pulses: got %0d, expected 2", pulses); else n_pass++;
  endtask

  task automatic test_flush();
    bit seen;
    do_reset();
    a_busy = 1;
    for (int i = 0; i < 5; i++) begin
      a_dv = 1; a_din = W'($urandom_range(0, 31));
      step();
    end
    a_dv = 0;
    n_checks++; if (a_ovf !== 16'd1) $display("FAIL fl_ovf_pre: got %0d, expected 1", a_ovf); else n_pass++;
    a_flush = 1;
    step();
    a_flush = 0;
    // Leave the write pointer away from zero before the checked flush.
    for (int i = 0; i < 3; i++) begin
      a_dv = 1; a_din = W'($urandom_range(0, 31));
      step();
    end
    a_dv = 1; a_flush = 1; a_din = 5'd30;
    step();
    a_dv = 0; a_flush = 0;
    n_checks++; if (a_count !== 3'd0) $display("FAIL fl_count: got %0d, expected 0", a_count); else n_pass++;
    n_checks++; if (a_empty !== 1'b1) $display("FAIL fl_empty: got %0b, expected 1", a_empty); else n_pass++;
    n_checks++; if (a_full !== 1'b0) $display("FAIL fl_full: got %0b, expected 0", a_full); else n_pass++;
    n_checks++; if (a_ovf !== 16'd1) $display("FAIL fl_ovf: got %0d, expected 1", a_ovf); else n_pass++;
    a_busy = 0;
    seen = 0;
    repeat (4) begin
      step();
      if (a_dvo) seen = 1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL fl_no_issue: got %0b, expected 0", seen); else n_pass++;
    a_dv = 1; a_din = 5'd21;
    step();
    a_dv = 0;
    step();
    n_checks++; if (a_dvo !== 1'b1) $display("FAIL fl_post_dvo: got %0b, expected 1", a_dvo); else n_pass++;
    n_checks++; if (a_dout !== 5'd21) $display("FAIL fl_post_dout: got %0d, expected 21", a_dout); else n_pass++;
  endtask

  task automatic test_wrap();
    int exp_q[$];
    int pushed, issued, busy_cnt, max_count;
    do_reset();
    pushed = 0; issued = 0; busy_cnt = 0; max_count = 0;
    for (int c = 0; c < 600 && issued < 13; c++) begin
      b_dv = (pushed < 13) && !b_full && ($urandom_range(0, 3) != 0);
      if (b_dv) begin
        b_din = W'($urandom_range(0, 31));
        exp_q.push_back(int'(b_din));
        pushed++;
      end
      b_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      step();
      if (int'(b_count) > max_count) max_count = int'(b_count);
      if (b_dvo) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL wrap_order[%0d]: got %0d, expected no issue", issued, b_dout);
        end else begin
          if (int'(b_dout) !== exp_q[0])
            $display("FAIL wrap_order[%0d]: got %0d, expected %0d", issued, b_dout, exp_q[0]);
          else n_pass++;
          void'(exp_q.pop_front());
        end
        issued++;
        busy_cnt = int'($urandom_range(2, 6));
      end
    end
    b_dv = 0; b_busy = 0;
    n_checks++; if (issued !== 13) $display("FAIL wrap_issued: got %0d, expected 13", issued); else n_pass++;
    n_checks++; if (max_count > 5) $display("FAIL wrap_max_count: got %0d, expected <= 5", max_count); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      a_dv    = ($urandom_range(0, 1) == 1);
      a_din   = W'($urandom_range(0, 31));
      a_flush = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) a_busy = ~a_busy;
      step();
      n_checks++; if (a_dvo !== m_dvo) $display("FAIL rnd_dvo@%0d: got %0b, expected %0b", c, a_dvo, m_dvo); else n_pass++;
      n_checks++; if (int'(a_dout) !== m_dout) $display("FAIL rnd_dout@%0d: got %0d, expected %0d", c, a_dout, m_dout); else n_pass++;
      n_checks++; if (int'(a_count) !== m_q.size()) $display("FAIL rnd_count@%0d: got %0d, expected %0d", c, a_count, m_q.size()); else n_pass++;
      n_checks++; if (a_empty !== (m_q.size() == 0)) $display("FAIL rnd_empty@%0d: got %0b", c, a_empty); else n_pass++;
      n_checks++; if (a_full !== (m_q.size() == DA)) $display("FAIL rnd_full@%0d: got %0b", c, a_full); else n_pass++;
      n_checks++; if (int'(a_ovf) !== m_ovf) $display("FAIL rnd_ovf@%0d: got %0d, expected %0d", c, a_ovf, m_ovf); else n_pass++;
      n_checks++; if (a_tmo !== m_tmo) $display("FAIL rnd_tmo@%0d: got %0b, expected %0b", c, a_tmo, m_tmo); else n_pass++;
    end
    a_dv = 0; a_flush = 0; a_busy = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_simul_push_pop();
    test_timeout();
    test_flush();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
